// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter
//   Two-master to one-slave AXI4-Lite arbiter. m0 (IFU) is read-only and m1
//   (LSU) has full read/write channels. Only one transaction is outstanding on
//   the s_* port at a time. A watchdog abandons a transaction whose response
//   never arrives and answers the granted master with SLVERR instead.
//
// Parameters
//   TIMEOUT      response-wait limit in cycles, 0 disables the watchdog
//   ROUND_ROBIN  contested reads: 0 = m1 always wins, 1 = alternate masters
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   m0_ar*, m0_r*     IFU read address / read data channels
//   m1_aw*, m1_w*,    LSU write address / write data / write response,
//   m1_b*, m1_ar*,    read address and read data channels
//   m1_r*
//   s_*               AXI4-Lite master port toward the memory slave
//   timeout_err       one-cycle pulse when the watchdog fires
//   dbg_state         current FSM state (IDLE=0 RD_M0=1 RD_M1=2 WR_M1=3 ERR=4)
//
// Handshake semantics: a transfer happens on a channel in the cycle where
// both valid and ready are high. This block routes valid/ready only while a
// master holds the grant; in IDLE and ERR nothing reaches the slave, and in
// IDLE nothing reaches either master.
module axi_lite_arbiter #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        rst,
  // m0 read address
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arprot,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  // m0 read data
  output logic [63:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // m1 write address
  input  logic [31:0] m1_awaddr,
  input  logic [2:0]  m1_awprot,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  // m1 write data
  input  logic [63:0] m1_wdata,
  input  logic [7:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  // m1 write response
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  // m1 read address
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arprot,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  // m1 read data
  output logic [63:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // slave write address
  output logic [31:0] s_awaddr,
  output logic [2:0]  s_awprot,
  output logic        s_awvalid,
  input  logic        s_awready,
  // slave write data
  output logic [63:0] s_wdata,
  output logic [7:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  // slave write response
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,
  // slave read address
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arprot,
  output logic        s_arvalid,
  input  logic        s_arready,
  // slave read data
  input  logic [63:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  // status
  output logic        timeout_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_M0 = 3'd1,
    RD_M1 = 3'd2,
    WR_M1 = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  state_t          gnt_q, gnt_d;           // granted state, remembered for ERR
  logic            last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
  logic            addr_done_q, addr_done_d;    // AW (write) or AR (read) done
  logic            w_done_q, w_done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            resp_hs;

  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;

  // Channel routing: purely a function of the current state, so a request
  // only reaches the slave from the cycle after the grant decision.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    s_awaddr   = '0;
    s_awprot   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    s_araddr   = '0;
    s_arprot   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    case (state_q)
      RD_M0: begin
        s_araddr   = m0_araddr;
        s_arprot   = m0_arprot;
        s_arvalid  = m0_arvalid & ~addr_done_q;
        m0_arready = s_arready & ~addr_done_q;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      RD_M1: begin
        s_araddr   = m1_araddr;
        s_arprot   = m1_arprot;
        s_arvalid  = m1_arvalid & ~addr_done_q;
        m1_arready = s_arready & ~addr_done_q;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      WR_M1: begin
        // AW and W are tracked separately so they may finish in any order.
        s_awaddr   = m1_awaddr;
        s_awprot   = m1_awprot;
        s_awvalid  = m1_awvalid & ~addr_done_q;
        m1_awready = s_awready & ~addr_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done_q;
        m1_wready  = s_wready & ~w_done_q;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      ERR: begin
        // Synthesised SLVERR toward whichever master held the grant.
        case (gnt_q)
          RD_M0: begin
            m0_rvalid = 1'b1;
            m0_rresp  = 2'b10;
          end
          RD_M1: begin
            m1_rvalid = 1'b1;
            m1_rresp  = 2'b10;
          end
          default: begin
            m1_bvalid = 1'b1;
            m1_bresp  = 2'b10;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign resp_hs = (s_rvalid & s_rready) | (s_bvalid & s_bready);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    addr_done_d   = addr_done_q;
    w_done_d      = w_done_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        addr_done_d = 1'b0;
        w_done_d    = 1'b0;
        if (m1_awvalid && m1_wvalid) begin
          state_d = WR_M1;
        end else if (m1_arvalid && m0_arvalid) begin
          // last_grant_q resets to m0, so the first contest goes to m1.
          if (ROUND_ROBIN != 0 && last_grant_q) state_d = RD_M0;
          else                                  state_d = RD_M1;
        end else if (m1_arvalid) begin
          state_d = RD_M1;
        end else if (m0_arvalid) begin
          state_d = RD_M0;
        end
        if (state_d == RD_M0) last_grant_d = 1'b0;
        if (state_d == RD_M1) last_grant_d = 1'b1;
        if (state_d != IDLE)  gnt_d = state_d;
      end
      RD_M0, RD_M1, WR_M1: begin
        cnt_d = cnt_q + CW'(1);
        if ((s_arvalid && s_arready) || (s_awvalid && s_awready)) addr_done_d = 1'b1;
        if (s_wvalid && s_wready) w_done_d = 1'b1;
        if (resp_hs) begin
          state_d = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end
      end
      ERR: begin
        if ((gnt_q == RD_M0 && m0_rready) ||
            (gnt_q == RD_M1 && m1_rready) ||
            (gnt_q == WR_M1 && m1_bready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= IDLE;
      last_grant_q  <= 1'b0;
      addr_done_q   <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_grant_q  <= last_grant_d;
      addr_done_q   <= addr_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter. dut0 uses TIMEOUT=8, fixed priority; dut1 uses
// TIMEOUT=0, round robin. Both share every input and one reset; only the
// outputs of the instance under discussion are compared in each sequence.
module tb_axi_lite_arbiter;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_WR1  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic clk, rst;
  logic [31:0] m0_araddr, m1_awaddr, m1_araddr;
  logic [2:0]  m0_arprot, m1_awprot, m1_arprot;
  logic        m0_arvalid, m0_rready, m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
  logic [63:0] m1_wdata, s_rdata;
  logic [7:0]  m1_wstrb;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;

  // dut0 outputs
  logic        m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata, s_wdata;
  logic [1:0]  m0_rresp, m1_bresp, m1_rresp;
  logic [31:0] s_awaddr, s_araddr;
  logic [2:0]  s_awprot, s_arprot, dbg0;
  logic [7:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, timeout_err;
  // dut1 outputs
  logic        b_m0_arready, b_m0_rvalid, b_m1_awready, b_m1_wready, b_m1_bvalid, b_m1_arready, b_m1_rvalid;
  logic [63:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic [1:0]  b_m0_rresp, b_m1_bresp, b_m1_rresp;
  logic [31:0] b_s_awaddr, b_s_araddr;
  logic [2:0]  b_s_awprot, b_s_arprot, dbg1;
  logic [7:0]  b_s_wstrb;
  logic        b_s_awvalid, b_s_wvalid, b_s_bready, b_s_arvalid, b_s_rready, b_timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  axi_lite_arbiter #(.TIMEOUT(8), .ROUND_ROBIN(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .timeout_err(timeout_err), .dbg_state(dbg0)
  );

  axi_lite_arbiter #(.TIMEOUT(0), .ROUND_ROBIN(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready),
    .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp), .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(b_m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(b_m1_wready),
    .m1_bresp(b_m1_bresp), .m1_bvalid(b_m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready),
    .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp), .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(b_s_awaddr), .s_awprot(b_s_awprot), .s_awvalid(b_s_awvalid), .s_awready(s_awready),
    .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(b_s_bready),
    .s_araddr(b_s_araddr), .s_arprot(b_s_arprot), .s_arvalid(b_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(b_s_rready),
    .timeout_err(b_timeout_err), .dbg_state(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arprot = '0; m0_arvalid = 0; m0_rready = 0;
    m1_awaddr = '0; m1_awprot = '0; m1_awvalid = 0;
    m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    m1_araddr = '0; m1_arprot = '0; m1_arvalid = 0; m1_rready = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    nxt();
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] hs_outs0();
    return {m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid, m1_arready,
            m1_rvalid, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
  endfunction

  function automatic logic [11:0] hs_outs1();
    return {b_m0_arready, b_m0_rvalid, b_m1_awready, b_m1_wready, b_m1_bvalid, b_m1_arready,
            b_m1_rvalid, b_s_awvalid, b_s_wvalid, b_s_bready, b_s_arvalid, b_s_rready};
  endfunction

  // driver: single m0 read on dut0, rvalid lat cycles after the grant cycle.
  // Starts just after a posedge with the DUT in IDLE; ends at a negedge.
  task automatic do_m0_read(input logic [31:0] addr, input logic [63:0] data, input int lat);
    m0_araddr = addr; m0_arprot = 3'd0; m0_arvalid = 1; m0_rready = 1;
    @(negedge clk);
    chk("rd_idle_state", dbg0, ST_IDLE);
    chk("rd_idle_no_fwd", hs_outs0(), 0);
    nxt();
    s_arready = 1;
    @(negedge clk);
    chk("rd_grant_state", dbg0, ST_RD0);
    chk("rd_s_araddr", s_araddr, addr);
    chk("rd_s_arvalid", s_arvalid, 1);
    chk("rd_m0_arready", m0_arready, 1);
    nxt();
    m0_arvalid = 0; s_arready = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("rd_wait_rvalid", m0_rvalid, 0);
      nxt();
    end
    s_rvalid = 1; s_rdata = data; s_rresp = 2'b00;
    @(negedge clk);
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m0_rdata", m0_rdata, data);
    chk("rd_m0_rresp", m0_rresp, 2'b00);
    chk("rd_s_rready", s_rready, 1);
    nxt();
    s_rvalid = 0; s_rdata = '0; m0_rready = 0;
    @(negedge clk);
    chk("rd_back_idle", dbg0, ST_IDLE);
    chk("rd_m0_rvalid_low", m0_rvalid, 0);
  endtask

  typedef struct {
    logic       aw;
    logic       w;
    logic       ar1;
    logic       ar0;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_WR1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, ST_WR1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_RD1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_RD1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_RD0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, ST_RD0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, ST_RD0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, ST_RD1};

    rst = 1'b1;
    clear_inputs();

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset_state", dbg0, ST_IDLE);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_hs_outs", hs_outs0(), 0);

    // grant decision table (fresh reset each time, so dut1 also sees m1 first)
    for (int i = 0; i < 9; i++) begin
      do_reset();
      m1_awvalid = vecs[i].aw; m1_wvalid = vecs[i].w;
      m1_arvalid = vecs[i].ar1; m0_arvalid = vecs[i].ar0;
      m1_awaddr = 32'h0000_1234; m1_araddr = 32'h0000_5678; m0_araddr = 32'h0000_9abc;
      s_awready = 1; s_wready = 1; s_arready = 1;
      @(negedge clk);
      chk($sformatf("tbl%0d_idle_outs0", i), hs_outs0(), 0);
      chk($sformatf("tbl%0d_idle_outs1", i), hs_outs1(), 0);
      nxt();
      @(negedge clk);
      chk($sformatf("tbl%0d_state0", i), dbg0, vecs[i].exp_state);
      chk($sformatf("tbl%0d_state1", i), dbg1, vecs[i].exp_state);
    end

    // single m0 read, data 3 cycles after grant
    do_reset();
    do_m0_read(32'h8000_0000, 64'h1122_3344_5566_7788, 3);

    // contested read, fixed priority: m1 then one IDLE cycle then m0
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0100; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h8000_0200; m1_rready = 1;
    s_arready = 1;
    nxt();
    s_rvalid = 1; s_rdata = 64'hAAAA_0000_0000_0001;
    @(negedge clk);
    chk("fix_first_state", dbg0, ST_RD1);
    chk("fix_first_addr", s_araddr, 32'h8000_0200);
    chk("fix_m1_rdata", m1_rdata, 64'hAAAA_0000_0000_0001);
    chk("fix_m0_quiet", {m0_arready, m0_rvalid}, 0);
    nxt();
    m1_arvalid = 0; s_rvalid = 0;
    @(negedge clk);
    chk("fix_gap_idle", dbg0, ST_IDLE);
    nxt();
    s_rvalid = 1; s_rdata = 64'hBBBB_0000_0000_0002;
    @(negedge clk);
    chk("fix_second_state", dbg0, ST_RD0);
    chk("fix_second_addr", s_araddr, 32'h8000_0100);
    chk("fix_m0_rdata", m0_rdata, 64'hBBBB_0000_0000_0002);
    nxt();
    m0_arvalid = 0; s_rvalid = 0;
    @(negedge clk);
    chk("fix_end_idle", dbg0, ST_IDLE);

    // two contested rounds: dut1 alternates m1, m0; dut0 stays on m1
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0300; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h8000_0400; m1_rready = 1;
    s_arready = 1;
    nxt();
    s_rvalid = 1; s_rdata = 64'h0000_0000_CAFE_0001;
    @(negedge clk);
    chk("rr_round1_dut1", dbg1, ST_RD1);
    chk("rr_round1_dut0", dbg0, ST_RD1);
    chk("rr_round1_m1_rdata", b_m1_rdata, 64'h0000_0000_CAFE_0001);
    nxt();
    s_rvalid = 0;
    @(negedge clk);
    chk("rr_gap_idle", dbg1, ST_IDLE);
    nxt();
    s_rvalid = 1; s_rdata = 64'h0000_0000_CAFE_0002;
    @(negedge clk);
    chk("rr_round2_dut1", dbg1, ST_RD0);
    chk("rr_round2_dut0", dbg0, ST_RD1);
    chk("rr_round2_addr1", b_s_araddr, 32'h8000_0300);
    chk("rr_round2_m0_rdata", b_m0_rdata, 64'h0000_0000_CAFE_0002);
    chk("rr_round2_m1_quiet", b_m1_rvalid, 0);
    nxt();
    m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0;
    @(negedge clk);
    chk("rr_end_idle", dbg1, ST_IDLE);

    // write, W accepted before AW, m0 request pending throughout
    do_reset();
    m1_awvalid = 1; m1_awaddr = 32'h8000_0010; m1_awprot = 3'd0;
    m1_wvalid = 1; m1_wdata = 64'h0102_0304_0506_0708; m1_wstrb = 8'h0F; m1_bready = 1;
    m0_arvalid = 1; m0_araddr = 32'h8000_0800;
    nxt();
    s_wready = 1;
    @(negedge clk);
    chk("wr_state", dbg0, ST_WR1);
    chk("wr_s_awaddr", s_awaddr, 32'h8000_0010);
    chk("wr_s_wstrb", s_wstrb, 8'h0F);
    chk("wr_s_wdata", s_wdata, 64'h0102_0304_0506_0708);
    chk("wr_valids", {s_awvalid, s_wvalid}, 2'b11);
    chk("wr_w_first", {m1_awready, m1_wready}, 2'b01);
    chk("wr_m0_arready_a", m0_arready, 0);
    nxt();
    m1_wvalid = 0; s_wready = 0; s_awready = 1;
    @(negedge clk);
    chk("wr_aw_second", {m1_awready, s_awvalid, s_wvalid}, 3'b110);
    chk("wr_m0_arready_b", m0_arready, 0);
    nxt();
    m1_awvalid = 0; s_awready = 0; s_bvalid = 1; s_bresp = 2'b00;
    @(negedge clk);
    chk("wr_m1_bvalid", m1_bvalid, 1);
    chk("wr_m1_bresp", m1_bresp, 2'b00);
    chk("wr_s_bready", s_bready, 1);
    chk("wr_m0_arready_c", m0_arready, 0);
    nxt();
    s_bvalid = 0; m0_arvalid = 0;
    @(negedge clk);
    chk("wr_back_idle", dbg0, ST_IDLE);
    chk("wr_m1_bvalid_low", m1_bvalid, 0);

    // watchdog: slave never returns rvalid
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0040;
    nxt();
    s_arready = 1;
    @(negedge clk);
    chk("to_grant_state", dbg0, ST_RD0);
    nxt();
    m0_arvalid = 0; s_arready = 0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_state", k), dbg0, ST_RD0);
      chk($sformatf("to_wait%0d_err", k), timeout_err, 0);
      nxt();
    end
    s_rvalid = 1; s_rdata = 64'hDEAD_BEEF_DEAD_BEEF;  // late response
    @(negedge clk);
    chk("to_err_state", dbg0, ST_ERR);
    chk("to_pulse", timeout_err, 1);
    chk("to_m0_rvalid", m0_rvalid, 1);
    chk("to_m0_rresp", m0_rresp, 2'b10);
    chk("to_m0_rdata", m0_rdata, 64'h0);
    chk("to_s_rready", s_rready, 0);
    nxt();
    m0_rready = 1;
    @(negedge clk);
    chk("to_pulse_end", timeout_err, 0);
    chk("to_err_hold", {m0_rvalid, s_rready, s_arvalid}, 3'b100);
    nxt();
    s_rvalid = 0; m0_rready = 0;
    @(negedge clk);
    chk("to_back_idle", dbg0, ST_IDLE);
    chk("to_m0_rvalid_low", m0_rvalid, 0);

    // reset during WR_M1 with bvalid pending, reset overriding requests
    do_reset();
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h8000_0020; m1_wstrb = 8'hFF; m1_bready = 0;
    nxt();
    s_awready = 1; s_wready = 1;
    @(negedge clk);
    chk("rst_wr_state", dbg0, ST_WR1);
    nxt();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
    @(negedge clk);
    chk("rst_b_pending", m1_bvalid, 1);
    rst = 1; m0_arvalid = 1; m1_arvalid = 1;
    nxt();
    @(negedge clk);
    chk("rst_idle_state", dbg0, ST_IDLE);
    chk("rst_idle_outs", hs_outs0(), 0);
    nxt();
    rst = 0; m0_arvalid = 0; m1_arvalid = 0; s_bvalid = 0;
    @(negedge clk);
    chk("rst_override", dbg0, ST_IDLE);
    nxt();
    do_m0_read(32'h8000_0080, 64'h0F0E_0D0C_0B0A_0908, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
